udma_rx_packer: RTL

- Peripheral-clock-domain stage directly upstream of the uDMA dual-clock RX FIFO.
- Accepts 8/16/32-bit samples from a peripheral RX datapath and packs them little-endian into DATA_WIDTH-bit words, with a valid-byte count per word.
- Its output handshake drives the FIFO source side.
- Supports explicit flush of a partially filled word, e.g. at end of transfer or on RX timeout.

---
 rtl/udma_rx_pkg.sv | 21 ++
 rtl/udma_rx_out_reg.sv | 53 +++++
 rtl/udma_rx_packer.sv | 116 +++++++++++
 3 files changed

// File: rtl/udma_rx_pkg.sv
// Shared types for the uDMA RX packer and the matching TX unpacker.
// Sample-size encoding plus its byte-count decode.
package udma_rx_pkg;

    typedef enum logic [1:0] {
        SIZE_8    = 2'd0,
        SIZE_16   = 2'd1,
        SIZE_32   = 2'd2,
        SIZE_RSVD = 2'd3
    } rx_size_e;

    // The reserved encoding decodes as a 4-byte sample.
    function automatic logic [2:0] size_bytes(input rx_size_e s);
        case (s)
            SIZE_8:  return 3'd1;
            SIZE_16: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/udma_rx_out_reg.sv
// Single-entry valid/ready output register for a data word plus byte count.
// A load may coincide with a pop, which gives one word per cycle.
module udma_rx_out_reg #(
    parameter int DW = 32,
    parameter int BW = 3
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          load_i,
    input  logic [DW-1:0] load_data_i,
    input  logic [BW-1:0] load_bytes_i,
    output logic [DW-1:0] out_data_o,
    output logic [BW-1:0] out_bytes_o,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic          free_o
);

    logic [DW-1:0] data_q, data_d;
    logic [BW-1:0] bytes_q, bytes_d;
    logic          valid_q, valid_d;

    always_comb begin
        data_d  = data_q;
        bytes_d = bytes_q;
        valid_d = valid_q;
        if (load_i) begin
            data_d  = load_data_i;
            bytes_d = load_bytes_i;
            valid_d = 1'b1;
        end else if (valid_q && out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            data_q  <= '0;
            bytes_q <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            bytes_q <= bytes_d;
            valid_q <= valid_d;
        end
    end

    assign out_data_o  = data_q;
    assign out_bytes_o = bytes_q;
    assign out_valid_o = valid_q;
    assign free_o      = ~valid_q | out_ready_i;

endmodule

// File: rtl/udma_rx_packer.sv
// Packs 8/16/32-bit RX samples little-endian into DATA_WIDTH-bit words
// ahead of the uDMA RX FIFO, with flush of a partially filled word.
module udma_rx_packer
    import udma_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                              clk_i,
    input  logic                              rstn_i,
    input  logic                              cfg_en_i,
    input  logic [1:0]                        cfg_size_i,
    input  logic                              flush_i,
    output logic                              flush_done_o,
    input  logic [31:0]                       in_data_i,
    input  logic                              in_valid_i,
    output logic                              in_ready_o,
    output logic [DATA_WIDTH-1:0]             out_data_o,
    output logic [$clog2(DATA_WIDTH/8):0]     out_bytes_o,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic                              busy_o
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int CW = $clog2(NB);
    localparam int BW = CW + 1;

    logic [DATA_WIDTH-1:0] acc_q, acc_d, acc_m, merged;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         cnt_m, n_ext;
    logic                  pend_q, pend_d;
    logic                  flush_done_q, flush_done_d;
    logic                  hs, full, slot_free, flush_req, load;
    int                    off;

    assign n_ext      = BW'(size_bytes(rx_size_e'(cfg_size_i)));
    assign in_ready_o = cfg_en_i & slot_free & ~pend_q;
    assign hs         = in_valid_i & in_ready_o;

    // Drop the sample into lanes [cnt .. cnt+n-1]; lanes above cnt are zero.
    always_comb begin
        merged = acc_q;
        off    = 0;
        for (int b = 0; b < NB; b++) begin
            off = b - int'(cnt_q);
            if (off >= 0 && off < int'(n_ext))
                merged[8*b +: 8] = in_data_i[{off[1:0], 3'b000} +: 8];
        end
    end

    assign acc_m     = hs ? merged : acc_q;
    assign cnt_m     = hs ? ({1'b0, cnt_q} + n_ext) : {1'b0, cnt_q};
    assign full      = hs && (cnt_m == BW'(NB));
    assign flush_req = cfg_en_i & (pend_q | flush_i);

    // A new flush is evaluated in its own cycle so a coincident sample
    // lands in the flushed word; pending only covers a stalled output slot.
    always_comb begin
        acc_d        = acc_m;
        cnt_d        = cnt_m[CW-1:0];
        pend_d       = flush_req;
        flush_done_d = 1'b0;
        load         = 1'b0;
        if (full) begin
            load  = 1'b1;
            acc_d = '0;
            cnt_d = '0;
        end
        if (flush_req && slot_free) begin
            if (cnt_m != '0) load = 1'b1;
            acc_d        = '0;
            cnt_d        = '0;
            pend_d       = 1'b0;
            flush_done_d = 1'b1;
        end
        if (!cfg_en_i) begin
            acc_d  = '0;
            cnt_d  = '0;
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            pend_q       <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            flush_done_q <= flush_done_d;
        end
    end

    udma_rx_out_reg #(
        .DW (DATA_WIDTH),
        .BW (BW)
    ) u_out_reg (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .load_i       (load),
        .load_data_i  (acc_m),
        .load_bytes_i (cnt_m),
        .out_data_o   (out_data_o),
        .out_bytes_o  (out_bytes_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .free_o       (slot_free)
    );

    assign flush_done_o = flush_done_q;
    assign busy_o       = (cnt_q != '0) | out_valid_o | pend_q;

endmodule
